accum_seq: RTL and testbench

ACCUM_SEQ -- requirements
Module: accum_seq

---
 rtl/accum_seq.sv | 112 +++++++++++
 tb/tb_accum_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_seq.sv
// rtl/accum_seq.sv - accumulator with manual IDLE ops and counted sample runs
// IDLE/RUN/DONE sequencer around an AW-bit accumulator with sticky overflow.
module accum_seq #(
  parameter int DW     = 4,
  parameter int AW     = 8,
  parameter int CW     = 4,
  parameter int THRESH = 127,
  parameter int SAT    = 0
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [1:0]    op,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic [DW-1:0] A,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] F,
  output logic          fgt,
  output logic          ovf,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_f;
  logic [AW-1:0] w_f_nxt;
  logic          r_ovf;
  logic          w_ovf_nxt;
  logic [CW-1:0] r_rem;
  logic [CW-1:0] w_rem_nxt;

  logic [AW:0]   w_sum;
  logic          w_carry;
  logic [AW-1:0] w_add_f;

  // One extra bit of sum width exposes the carry that drives ovf and saturation.
  assign w_sum   = {1'b0, r_f} + (AW+1)'(A);
  assign w_carry = w_sum[AW];
  assign w_add_f = ((SAT != 0) && w_carry) ? {AW{1'b1}} : w_sum[AW-1:0];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_f     <= '0;
      r_ovf   <= 1'b0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_f     <= w_f_nxt;
      r_ovf   <= w_ovf_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_f_nxt     = r_f;
    w_ovf_nxt   = r_ovf;
    w_rem_nxt   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_f_nxt     = '0;
          w_ovf_nxt   = 1'b0;
          w_rem_nxt   = count;
          w_state_nxt = (count != '0) ? S_RUN : S_DONE;
        end else begin
          case (op)
            2'b00: begin
              w_f_nxt   = '0;
              w_ovf_nxt = 1'b0;
            end
            2'b01: w_f_nxt = AW'(A);
            2'b10: begin
              w_f_nxt   = w_add_f;
              w_ovf_nxt = r_ovf | w_carry;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (in_valid) begin
          w_f_nxt   = w_add_f;
          w_ovf_nxt = r_ovf | w_carry;
          w_rem_nxt = r_rem - CW'(1);
          if (r_rem == CW'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign F        = r_f;
  assign ovf      = r_ovf;
  assign fgt      = (r_f > AW'(THRESH));
  assign in_ready = (r_state == S_RUN);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_accum_seq.sv
// tb/tb_accum_seq.sv - bench for accum_seq (wrap and saturate instances)
module tb_accum_seq;

  localparam int MAXV = 255;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic [1:0] op    = 2'b11;
  logic       start = 1'b0;
  logic [3:0] count = 4'd0;
  logic [3:0] A     = 4'd0;
  logic       in_valid = 1'b0;

  logic       in_ready0, fgt0, ovf0, busy0, done0;
  logic [7:0] F0;
  logic       in_ready1, fgt1, ovf1, busy1, done1;
  logic [7:0] F1;

  int errors = 0;
  int checks = 0;

  // Reference state: accumulator value per overflow mode and run progress.
  int m_f[2];
  bit m_ovf[2];
  int m_left;
  bit m_running;
  bit m_done;

  always #5 clock = ~clock;

  accum_seq #(.DW(4), .AW(8), .CW(4), .THRESH(127), .SAT(0)) u_wrap (
    .clock(clock), .rst(rst), .op(op), .start(start), .count(count), .A(A),
    .in_valid(in_valid), .in_ready(in_ready0), .F(F0), .fgt(fgt0), .ovf(ovf0),
    .busy(busy0), .done(done0)
  );

  accum_seq #(.DW(4), .AW(8), .CW(4), .THRESH(127), .SAT(1)) u_sat (
    .clock(clock), .rst(rst), .op(op), .start(start), .count(count), .A(A),
    .in_valid(in_valid), .in_ready(in_ready1), .F(F1), .fgt(fgt1), .ovf(ovf1),
    .busy(busy1), .done(done1)
  );

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_f[s]   = 0;
      m_ovf[s] = 1'b0;
    end
    m_left    = 0;
    m_running = 1'b0;
    m_done    = 1'b0;
  endfunction

  function automatic void model_add(int a);
    for (int s = 0; s < 2; s++) begin
      int sum;
      sum = m_f[s] + a;
      if (sum > MAXV) begin
        m_ovf[s] = 1'b1;
        m_f[s]   = (s == 1) ? MAXV : sum - (MAXV + 1);
      end else begin
        m_f[s] = sum;
      end
    end
  endfunction

  function automatic void model_step(int o, bit st, int cnt, int a, bit v);
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_running) begin
      if (v) begin
        model_add(a);
        m_left--;
        if (m_left == 0) begin
          m_running = 1'b0;
          m_done    = 1'b1;
        end
      end
    end else if (st) begin
      for (int s = 0; s < 2; s++) begin
        m_f[s]   = 0;
        m_ovf[s] = 1'b0;
      end
      m_left = cnt;
      if (cnt == 0) m_done = 1'b1;
      else m_running = 1'b1;
    end else begin
      case (o)
        0: for (int s = 0; s < 2; s++) begin m_f[s] = 0; m_ovf[s] = 1'b0; end
        1: for (int s = 0; s < 2; s++) m_f[s] = a;
        2: model_add(a);
        default: ;
      endcase
    end
  endfunction

  // Drive one cycle of inputs, clock it, advance the model, settle 1ns past the edge.
  task automatic tick(input int o, input bit st, input int cnt, input int a, input bit v);
    op       = 2'(o);
    start    = st;
    count    = 4'(cnt);
    A        = 4'(a);
    in_valid = v;
    @(posedge clock);
    model_step(o, st, cnt, a, v);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({F0, ovf0, busy0, done0, in_ready0, fgt0} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got F=%0d ovf=%b busy=%b done=%b rdy=%b fgt=%b, want all 0",
               F0, ovf0, busy0, done0, in_ready0, fgt0);
    end
    @(posedge clock);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if ({F1, ovf1, busy1} !== 10'd0) begin
      errors++;
      $display("FAIL reset_sat_inst: got F=%0d ovf=%b busy=%b, want 0", F1, ovf1, busy1);
    end
  endtask

  task automatic test_idle_ops();
    tick(1, 0, 0, 5, 0);
    checks++;
    if (F0 !== 8'd5) begin errors++; $display("FAIL idle_load: got %0d want 5", F0); end
    tick(2, 0, 0, 3, 0);
    checks++;
    if (F0 !== 8'd8) begin errors++; $display("FAIL idle_add: got %0d want 8", F0); end
    tick(3, 0, 0, 9, 1);
    checks++;
    if (F0 !== 8'd8) begin errors++; $display("FAIL idle_hold: got %0d want 8", F0); end
    tick(0, 0, 0, 9, 0);
    checks++;
    if ({F0, ovf0} !== 9'd0) begin
      errors++; $display("FAIL idle_clear: got F=%0d ovf=%b want 0/0", F0, ovf0);
    end
  endtask

  task automatic test_run();
    tick(1, 1, 3, 6, 0);
    checks++;
    if ({busy0, in_ready0, done0, F0} !== {3'b110, 8'd0}) begin
      errors++; $display("FAIL run_start: got busy=%b rdy=%b done=%b F=%0d want 1/1/0/0",
                         busy0, in_ready0, done0, F0);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 15, 1);
      if (i < 2) begin
        checks++;
        if ({busy0, done0, F0} !== {2'b10, 8'(15 * (i + 1))}) begin
          errors++; $display("FAIL run_accept%0d: got busy=%b done=%b F=%0d want 1/0/%0d",
                             i, busy0, done0, F0, 15 * (i + 1));
        end
        tick(0, 1, 5, $urandom_range(0, 15), 0);
        checks++;
        if ({busy0, done0, F0} !== {2'b10, 8'(15 * (i + 1))}) begin
          errors++; $display("FAIL run_gap%0d: got busy=%b done=%b F=%0d want 1/0/%0d",
                             i, busy0, done0, F0, 15 * (i + 1));
        end
      end
    end
    checks++;
    if ({busy0, done0, in_ready0, F0} !== {3'b110, 8'd45}) begin
      errors++; $display("FAIL run_done: got busy=%b done=%b rdy=%b F=%0d want 1/1/0/45",
                         busy0, done0, in_ready0, F0);
    end
    tick(3, 0, 0, 0, 1);
    checks++;
    if ({busy0, done0, F0} !== {2'b00, 8'd45}) begin
      errors++; $display("FAIL run_idle_after: got busy=%b done=%b F=%0d want 0/0/45",
                         busy0, done0, F0);
    end
  endtask

  task automatic test_threshold();
    tick(1, 0, 0, 15, 0);
    for (int i = 0; i < 7; i++) tick(2, 0, 0, 15, 0);
    checks++;
    if ({F0, fgt0} !== {8'd120, 1'b0}) begin
      errors++; $display("FAIL thresh_120: got F=%0d fgt=%b want 120/0", F0, fgt0);
    end
    tick(2, 0, 0, 7, 0);
    checks++;
    if ({F0, fgt0} !== {8'd127, 1'b0}) begin
      errors++; $display("FAIL thresh_127: got F=%0d fgt=%b want 127/0", F0, fgt0);
    end
    tick(2, 0, 0, 1, 0);
    checks++;
    if ({F0, fgt0} !== {8'd128, 1'b1}) begin
      errors++; $display("FAIL thresh_128: got F=%0d fgt=%b want 128/1", F0, fgt0);
    end
  endtask

  task automatic test_overflow();
    tick(1, 0, 0, 15, 0);
    for (int i = 0; i < 16; i++) tick(2, 0, 0, 15, 0);
    checks++;
    if ({F0, ovf0, F1, ovf1} !== {8'd255, 1'b0, 8'd255, 1'b0}) begin
      errors++; $display("FAIL ovf_edge: got wrap F=%0d ovf=%b sat F=%0d ovf=%b want 255/0 255/0",
                         F0, ovf0, F1, ovf1);
    end
    tick(2, 0, 0, 15, 0);
    checks++;
    if ({F0, ovf0} !== {8'd14, 1'b1}) begin
      errors++; $display("FAIL ovf_wrap: got F=%0d ovf=%b want 14/1", F0, ovf0);
    end
    checks++;
    if ({F1, ovf1} !== {8'd255, 1'b1}) begin
      errors++; $display("FAIL ovf_sat: got F=%0d ovf=%b want 255/1", F1, ovf1);
    end
    tick(2, 0, 0, 0, 0);
    checks++;
    if ({ovf0, ovf1} !== 2'b11) begin
      errors++; $display("FAIL ovf_sticky: got %b%b want 11", ovf0, ovf1);
    end
    tick(0, 0, 0, 0, 0);
    checks++;
    if ({F0, ovf0, F1, ovf1} !== 18'd0) begin
      errors++; $display("FAIL ovf_clear: got wrap F=%0d ovf=%b sat F=%0d ovf=%b want 0",
                         F0, ovf0, F1, ovf1);
    end
  endtask

  task automatic test_count_zero();
    tick(1, 0, 0, 9, 0);
    tick(1, 1, 0, 7, 1);
    checks++;
    if ({done0, in_ready0, busy0, F0} !== {3'b101, 8'd0}) begin
      errors++; $display("FAIL zero_done: got done=%b rdy=%b busy=%b F=%0d want 1/0/1/0",
                         done0, in_ready0, busy0, F0);
    end
    tick(1, 1, 0, 7, 1);
    checks++;
    if ({done0, in_ready0, busy0, F0} !== {3'b000, 8'd0}) begin
      errors++; $display("FAIL zero_idle: got done=%b rdy=%b busy=%b F=%0d want 0/0/0/0",
                         done0, in_ready0, busy0, F0);
    end
  endtask

  task automatic test_rst_mid_run();
    tick(2, 0, 0, 15, 0);
    tick(2, 0, 0, 15, 0);
    tick(3, 1, 3, 0, 0);
    tick(3, 0, 0, 15, 1);
    checks++;
    if (F0 !== 8'd15) begin errors++; $display("FAIL rst_pre: got F=%0d want 15", F0); end
    rst = 1'b1;
    #2;
    checks++;
    if ({F0, ovf0, busy0, done0, in_ready0} !== 12'd0) begin
      errors++; $display("FAIL rst_async: got F=%0d ovf=%b busy=%b done=%b rdy=%b want 0",
                         F0, ovf0, busy0, done0, in_ready0);
    end
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if ({busy0, done0} !== 2'b00) begin
      errors++; $display("FAIL rst_nodone: got busy=%b done=%b want 0/0", busy0, done0);
    end
    tick(3, 1, 1, 0, 0);
    tick(3, 0, 0, 9, 1);
    checks++;
    if ({F0, done0} !== {8'd9, 1'b1}) begin
      errors++; $display("FAIL rst_rerun: got F=%0d done=%b want 9/1", F0, done0);
    end
    tick(3, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [21:0] got;
      logic [21:0] exp;
      tick($urandom_range(0, 3), ($urandom_range(0, 5) == 0), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 1));
      got = {F0, ovf0, F1, ovf1, busy0, done0, in_ready0, fgt0};
      exp = {8'(m_f[0]), m_ovf[0], 8'(m_f[1]), m_ovf[1], (m_running | m_done), m_done,
             m_running, (m_f[0] > 127)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h want %h (F0,ovf0,F1,ovf1,busy,done,rdy,fgt)",
                 n, got, exp);
      end
      checks++;
      if ({busy1, done1, in_ready1, fgt1} !== {(m_running | m_done), m_done, m_running,
                                               (m_f[1] > 127)}) begin
        errors++;
        $display("FAIL random_sat_ctrl%0d: got %b%b%b%b want %b%b%b%b", n,
                 busy1, done1, in_ready1, fgt1, (m_running | m_done), m_done, m_running,
                 (m_f[1] > 127));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_ops();
    test_run();
    test_threshold();
    test_overflow();
    test_count_zero();
    test_rst_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
